// File: rtl/hamming_scrub_ctrl_if.sv
// hamming_scrub_ctrl_if: host request/response bus of the Hamming scrub controller
interface hamming_scrub_ctrl_if;
  logic       host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [7:0] host_addr, host_wdata, host_rdata;
  modport master(output host_req, host_we, host_addr, host_wdata,
                 input host_gnt, host_rvalid, host_rdata, host_err);
  modport slave(input host_req, host_we, host_addr, host_wdata,
                output host_gnt, host_rvalid, host_rdata, host_err);
endinterface

// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl: arbitrates host and background scrub access to a Hamming-protected 256x8 SRAM
module hamming_scrub_ctrl #(
  parameter int SCRUB_INTERVAL = 64,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hamming_scrub_ctrl_if.slave  host,
  input  logic                 i_scrub_en,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [7:0]           o_mem_addr,
  output logic [7:0]           o_mem_wdata,
  input  logic [7:0]           i_mem_rdata,
  input  logic                 i_mem_sec,
  input  logic                 i_mem_ded,
  output logic [7:0]           o_sec_cnt,
  output logic [7:0]           o_ded_cnt,
  output logic [7:0]           o_ded_addr,
  output logic                 o_pass_done
);
  localparam int TW = $clog2(SCRUB_INTERVAL);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, HRSP, SCHK} state_t;
  state_t        r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_starve;
  logic [7:0]    r_haddr, r_ptr, r_sec_cnt, r_ded_cnt, r_ded_addr;
  logic          w_due, w_hit, w_issue, w_chk, w_sec, w_ded;
  assign w_due = r_timer == '0 && i_scrub_en;
  assign w_hit = r_starve == SW'(STARVE_LIMIT);
  assign w_chk = r_state != IDLE;
  // a word flagged both SEC and DED is treated as uncorrectable
  assign w_ded = w_chk && i_mem_ded;
  assign w_sec = w_chk && i_mem_sec && !i_mem_ded;
  assign o_sec_cnt  = r_sec_cnt;
  assign o_ded_cnt  = r_ded_cnt;
  assign o_ded_addr = r_ded_addr;
  always_comb begin
    w_next           = r_state;
    w_issue          = 1'b0;
    host.host_gnt    = 1'b0;
    host.host_rvalid = 1'b0;
    host.host_rdata  = '0;
    host.host_err    = 1'b0;
    o_mem_en         = 1'b0;
    o_mem_we         = 1'b0;
    o_mem_addr       = '0;
    o_mem_wdata      = '0;
    o_pass_done      = 1'b0;
    // reset suppresses every access so a pending write-back is dropped
    if (!rst) begin
      if (r_state == IDLE) begin
        host.host_gnt = host.host_req && !(w_due && w_hit);
        w_issue       = w_due && !host.host_gnt;
        o_mem_en      = host.host_gnt || w_issue;
        o_mem_we      = host.host_gnt && host.host_we;
        o_mem_addr    = host.host_gnt ? host.host_addr : w_issue ? r_ptr : '0;
        o_mem_wdata   = host.host_gnt ? host.host_wdata : '0;
        w_next        = host.host_gnt && !host.host_we ? HRSP : w_issue ? SCHK : IDLE;
      end else begin
        host.host_rvalid = r_state == HRSP;
        host.host_rdata  = r_state == HRSP ? i_mem_rdata : '0;
        host.host_err    = r_state == HRSP && i_mem_ded;
        o_mem_en         = w_sec;
        o_mem_we         = w_sec;
        o_mem_addr       = w_sec ? (r_state == HRSP ? r_haddr : r_ptr) : '0;
        o_mem_wdata      = w_sec ? i_mem_rdata : '0;
        o_pass_done      = r_state == SCHK && r_ptr == 8'hFF;
        w_next           = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= TW'(SCRUB_INTERVAL - 1);
      r_starve   <= '0;
      r_haddr    <= '0;
      r_ptr      <= '0;
      r_sec_cnt  <= '0;
      r_ded_cnt  <= '0;
      r_ded_addr <= '0;
    end else begin
      r_state <= w_next;
      if (host.host_gnt) r_haddr <= host.host_addr;
      if (w_issue) r_timer <= TW'(SCRUB_INTERVAL - 1);
      else if (r_state == IDLE && i_scrub_en && r_timer != '0) r_timer <= r_timer - 1'b1;
      if (w_issue) r_starve <= '0;
      else if (host.host_gnt && w_due) r_starve <= r_starve + 1'b1;
      if (r_state == SCHK) r_ptr <= r_ptr + 8'd1;
      if (w_sec && r_sec_cnt != 8'hFF) r_sec_cnt <= r_sec_cnt + 8'd1;
      if (w_ded && r_ded_cnt != 8'hFF) r_ded_cnt <= r_ded_cnt + 8'd1;
      if (w_ded) r_ded_addr <= r_state == HRSP ? r_haddr : r_ptr;
    end
  end
endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// tb_hamming_scrub_ctrl: directed bench with a behavioural SRAM/decoder model and fault injection
module tb_hamming_scrub_ctrl;
  logic       clk = 0, rst = 1, scrub_en = 0;
  logic       mem_en, mem_we, pass_done;
  logic [7:0] mem_addr, mem_wdata, sec_cnt, ded_cnt, ded_addr;
  logic [7:0] mem_rdata = 0;
  logic       mem_sec = 0, mem_ded = 0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [1:0] flt [256] = '{default: 2'd0};
  logic       inj = 0, inj_all = 0;
  logic [7:0] inj_a = 0;
  logic [1:0] inj_k = 0;
  int         wr_cnt = 0;
  logic [7:0] wr_addr = 0, wr_data = 0;
  int         n_tests = 0, n_fail = 0;
  logic [7:0] rd_d, rd_wa, rd_wd;
  logic       rd_e, rd_rv0, rd_rv1, rd_wen, rd_wwe;
  hamming_scrub_ctrl_if bus();
  hamming_scrub_ctrl #(.SCRUB_INTERVAL(4), .STARVE_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .host(bus.slave), .i_scrub_en(scrub_en),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_sec(mem_sec), .i_mem_ded(mem_ded),
    .o_sec_cnt(sec_cnt), .o_ded_cnt(ded_cnt), .o_ded_addr(ded_addr), .o_pass_done(pass_done)
  );
  always #5 clk = ~clk;
  // SRAM + decoder: flt 1 = correctable single error, 2 = double error; writes re-encode cleanly
  always @(posedge clk) begin
    if (inj_all) for (int i = 0; i < 256; i++) flt[i] <= 2'd1;
    else if (inj) flt[inj_a] <= inj_k;
    mem_sec <= 1'b0;
    mem_ded <= 1'b0;
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      flt[mem_addr] <= 2'd0;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end else if (mem_en) begin
      mem_rdata <= flt[mem_addr] == 2'd2 ? mem[mem_addr] ^ 8'h03 : mem[mem_addr];
      mem_sec   <= flt[mem_addr] == 2'd1;
      mem_ded   <= flt[mem_addr] == 2'd2;
    end
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task inject(input logic [7:0] a, input logic [1:0] k);
    @(negedge clk);
    inj_a = a;
    inj_k = k;
    inj   = 1;
    @(negedge clk);
    inj = 0;
  endtask
  task host_acc(input logic we, input logic [7:0] a, input logic [7:0] d);
    int k;
    @(negedge clk);
    bus.host_req = 1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    #1;
    k = 0;
    while (k < 50 && !bus.host_gnt) begin
      @(negedge clk); #1;
      k++;
    end
    if (!bus.host_gnt) check("gnt_timeout", 0, 1);
  endtask
  task host_write(input logic [7:0] a, input logic [7:0] d);
    host_acc(1, a, d);
    check("wr_issue", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, a, d});
    @(negedge clk);
    bus.host_req = 0;
  endtask
  task host_read(input logic [7:0] a);
    host_acc(0, a, 8'h00);
    rd_rv0 = bus.host_rvalid;
    @(negedge clk);
    bus.host_req = 0;
    #1;
    rd_rv1 = bus.host_rvalid; rd_d = bus.host_rdata; rd_e = bus.host_err;
    rd_wen = mem_en; rd_wwe = mem_we; rd_wa = mem_addr; rd_wd = mem_wdata;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] ta [3] = '{8'd10, 8'd20, 8'd255};
    logic [7:0] td [3] = '{8'h2C, 8'h3C, 8'hFF};
    int k, w0, t1, t2, g1, g2, n, gap_rd;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outs", {bus.host_gnt, bus.host_rvalid, bus.host_err, mem_en, mem_we, pass_done}, 0);
    check("rst_cnts", {sec_cnt, ded_cnt, ded_addr, mem_addr}, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) host_write(ta[i], td[i]);
    for (int i = 0; i < 3; i++) begin
      host_read(ta[i]);
      check("rd_data", rd_d, td[i]);
      check("rd_valid_timing", {rd_rv0, rd_rv1}, 2'b01);
      check("rd_err", rd_e, 0);
    end
    inject(20, 1);
    host_read(20);
    check("sec_rdata", rd_d, 8'h3C);
    check("sec_writeback", {rd_wen, rd_wwe, rd_wa, rd_wd}, {2'b11, 8'd20, 8'h3C});
    @(negedge clk); #1;
    check("sec_cnt_1", sec_cnt, 1);
    host_read(20);
    check("reread_no_wb", {rd_wen, rd_d}, {1'b0, 8'h3C});
    host_write(40, 8'h4C);
    inject(40, 2);
    host_read(40);
    check("ded_err", {rd_rv1, rd_e}, 2'b11);
    check("ded_no_wb", rd_wen, 0);
    @(negedge clk); #1;
    check("ded_cnt_addr", {ded_cnt, ded_addr, sec_cnt}, {8'd1, 8'd40, 8'd1});
    host_write(40, 8'h4C);
    host_write(30, 8'h5A);
    inject(30, 1);
    w0 = wr_cnt;
    @(negedge clk);
    scrub_en = 1;
    k = 0;
    #1;
    while (k < 3000 && !pass_done) begin
      @(negedge clk); #1;
      k++;
    end
    check("pass_done_seen", pass_done, 1);
    @(negedge clk); #1;
    check("pass_done_pulse", pass_done, 0);
    check("scrub_wb", {wr_cnt - w0, 8'(wr_addr), 8'(wr_data)}, {32'd1, 8'd30, 8'h5A});
    check("scrub_sec_cnt", sec_cnt, 2);
    t1 = -1; t2 = -1;
    for (int c = 0; c < 40 && t2 < 0; c++) begin
      if (mem_en && !mem_we) begin
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
      @(negedge clk); #1;
    end
    check("scrub_period", t2 - t1, 5);
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 50; bus.host_wdata = 8'h11;
    #1;
    k = 0;
    while (k < 40 && !bus.host_gnt) begin @(negedge clk); #1; k++; end
    k = 0;
    while (k < 40 && bus.host_gnt) begin @(negedge clk); #1; k++; end
    gap_rd = {mem_en, mem_we} == 2'b10;
    g1 = 0;
    while (g1 < 10 && !bus.host_gnt) begin @(negedge clk); #1; g1++; end
    n = 0;
    while (n < 60 && bus.host_gnt) begin @(negedge clk); #1; n++; end
    g2 = 0;
    while (g2 < 10 && !bus.host_gnt) begin @(negedge clk); #1; g2++; end
    check("starve_gap_read", gap_rd, 1);
    check("starve_gap1", g1, 2);
    check("starve_grants", n, 19);
    check("starve_gap2", g2, 2);
    bus.host_req = 0;
    scrub_en = 0;
    host_write(60, 8'h6C);
    for (int i = 0; i < 260; i++) begin
      inject(60, 1);
      host_read(60);
    end
    @(negedge clk); #1;
    check("sec_saturate", sec_cnt, 255);
    check("sat_rdata", rd_d, 8'h6C);
    check("sat_ded_cnt", ded_cnt, 1);
    inj_all = 1;
    @(negedge clk);
    inj_all = 0;
    scrub_en = 1;
    #1;
    k = 0;
    while (k < 20 && !(mem_en && !mem_we)) begin @(negedge clk); #1; k++; end
    @(negedge clk); #1;
    check("schk_wb_pending", {mem_en, mem_we}, 2'b11);
    w0 = wr_cnt;
    rst = 1;
    scrub_en = 0;
    #1;
    check("rst_abandon_wb", mem_en, 0);
    @(negedge clk); #1;
    check("rst_mid_outs", {bus.host_gnt, bus.host_rvalid, mem_en, pass_done, sec_cnt, ded_cnt, ded_addr}, 0);
    check("rst_no_write", wr_cnt - w0, 0);
    rst = 0;
    scrub_en = 1;
    #1;
    k = 0;
    while (k < 20 && !(mem_en && !mem_we)) begin @(negedge clk); #1; k++; end
    check("ptr_after_rst", {mem_en, mem_addr}, {1'b1, 8'd0});
    scrub_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming_scrub_ctrl.md
# hamming_scrub_ctrl

Controller for the 256×8 Hamming-protected SRAM. It shares the single memory port between a host requester and a background scrub engine. The scrub engine walks every address, reads it, and writes back the corrected word when the decoder reports a single-bit error. Host reads that hit a single-bit error are also written back. The block sits between the host bus and the SRAM/encoder/decoder datapath, and keeps error statistics.

## Interface
- SCRUB_INTERVAL, default 64: idle cycles between scrub steps; legal range ≥2.
- STARVE_LIMIT, default 16: consecutive cycles a pending scrub may be deferred by the host before it takes priority.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- host_req  in  1  host access request; held until granted.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  8  host address.
- host_wdata  in  8  host write data.
- host_gnt  out  1  request accepted this cycle (req && gnt = transfer).
- host_rvalid  out  1  read data valid (1-cycle pulse).
- host_rdata  out  8  corrected read data.
- host_err  out  1  uncorrectable (double) error on this read; qualified by host_rvalid.
- scrub_en  in  1  enables background scrubbing.
- mem_en, mem_we  out  1 each  memory port enable / write.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  data to the encoder.
- mem_rdata  in  8  decoder-corrected data; valid the cycle after a read is issued.
- mem_sec, mem_ded  in  1 each  single-error-corrected / double-error-detected flags, aligned with mem_rdata.
- sec_cnt, ded_cnt  out  8 each  saturating error counters (host and scrub combined).
- ded_addr  out  8  address of the most recent double error.
- pass_done  out  1  1-cycle pulse when the scrub pointer wraps from 255 to 0.

## Operation
- FSM states: IDLE, HRSP (host read response), SCHK (scrub check).
- IDLE, host granted: host_gnt = 1 when host_req && !(scrub_due && starve_hit).
  - Write: issue mem_en = 1, mem_we = 1, addr, wdata; stay in IDLE.
  - Read: issue mem_en = 1, mem_we = 0; go to HRSP.
- HRSP:
  - host_rvalid = 1 and host_rdata = mem_rdata.
  - host_err = mem_ded.
  - If mem_sec: write mem_rdata back to the latched address in the same cycle.
  - host_gnt = 0; return to IDLE.
- Scrub timer:
  - Loaded with SCRUB_INTERVAL−1 at reset and after each scrub step.
  - Decrements in IDLE while scrub_en = 1; holds at 0.
  - scrub_due = (timer == 0) && scrub_en.
- Starvation counter: counts cycles with scrub_due && host_req granted to the host; starve_hit = (count == STARVE_LIMIT). It clears when a scrub step issues.
- IDLE, scrub issue: when scrub_due && (!host_req || starve_hit), issue a read of scrub_ptr, host_gnt = 0, go to SCHK.
- SCHK:
  - If mem_sec: write mem_rdata back to scrub_ptr (mem_we = 1).
  - If mem_ded: no write-back; ded_addr ← scrub_ptr.
  - scrub_ptr increments, wrapping 255→0 with a pass_done pulse.
  - host_gnt = 0; return to IDLE.
- Counters: sec_cnt increments on any mem_sec in HRSP/SCHK; ded_cnt increments on any mem_ded. Both saturate at 255. A host DED also updates ded_addr.
- If mem_sec and mem_ded are both asserted, treat the word as DED: no write-back; only ded_cnt increments.
- Deasserting scrub_en mid-step: the step in progress completes; the timer then freezes.
- Scrub read + write-back is atomic: the host cannot be granted between them.

## Timing
- Reset values: all outputs 0, scrub_ptr = 0, FSM = IDLE, counters 0, ded_addr 0.
- Reset asserted mid-operation: a pending write-back is abandoned; the state reverts on the next edge.
- Host write: 1 cycle, back-to-back writes allowed.
- Host read: address at cycle t, host_rvalid at t+1, next grant no earlier than t+2.
- Scrub step: 2 cycles (issue, check/write-back), once every SCRUB_INTERVAL+1 idle-permitting cycles.
- mem_* outputs are combinational from the FSM, registered state, and mem_rdata/flags. mem_en = 0 in any cycle with no access.

## Test plan
- Reset, then host writes 0x2C@10, 0x3C@20, 0xFF@255; read each back → host_rdata matches, host_rvalid one cycle after the grant, host_err = 0.
- Flip one bit of mem[20]; host read @20 → host_rdata = 0x3C, sec_cnt = 1, write-back of 0x3C@20 in the HRSP cycle; a re-read shows mem_sec = 0.
- Flip two bits of mem[40] after writing 0x4C; host read → host_err = 1, ded_cnt = 1, ded_addr = 40, no write-back.
- scrub_en = 1 and no host traffic, SCRUB_INTERVAL = 4; single-bit error at address 30 → scrub corrects it when scrub_ptr = 30; pass_done pulses after address 255; sec_cnt increments.
- Continuous host_req with scrub due → host granted STARVE_LIMIT times, then one scrub step is forced (host_gnt = 0 for 2 cycles), then the host resumes.
- Saturation: inject 260 single-bit errors → sec_cnt holds at 255. Assert rst during SCHK → all outputs 0 on the next cycle.
